dc_line_ctrl: RTL and testbench
===============================

DC_LINE_CTRL -- requirements
Module: dc_line_ctrl

Interface
REQ-001 SHALL have parameter DWIDTH, default 14, log2 of data RAM size in 32-bit words; line index width DWIDTH-2.
REQ-002 SHALL have ports (clock and reset first):
- clk  in  1  sole clock
- rst_n  in  1  reset, synchronous, active-low
- miss_req  in  1  one-cycle miss request from MA-side tag logic
- miss_adr  in  28  [31:4] byte-line address to fill
- victim_dirty  in  1  victim line needs writeback; sampled with miss_req
- victim_adr  in  28  [31:4] victim line address; sampled with miss_req
- ram_radr_all  out  DWIDTH-2  line read index into data RAM
- ram_ren_all  out  1  line read enable
- ram_rdata_all  in  128  line read data, valid cycle after ram_ren_all
- ram_wadr_all  out  DWIDTH-2  line write index
- ram_wdata_all  out  128  line write data
- ram_wen_all  out  1  line write enable
- mem_req  out  1  external memory request, held until mem_ack
- mem_we  out  1  1 = writeback, 0 = fill read
- mem_adr  out  28  [31:4] line address
- mem_wdata  out  128  writeback data
- mem_ack  in  1  request accepted
- mem_rvalid  in  1  fill data valid, one cycle
- mem_rdata  in  128  fill data
- busy  out  1  controller not idle
- dc_stall_fin  out  1  one-cycle pulse: line filled, MA may replay
- tag_upd  out  1  one-cycle pulse, same cycle as dc_stall_fin: write miss_adr tag, valid=1, dirty=0

Function
REQ-003 SHALL register miss_adr, victim_adr, victim_dirty when miss_req=1 in IDLE.
REQ-004 SHALL ignore miss_req while busy=1 (no queueing).
REQ-005 SHALL implement states IDLE, WB_RD, WB_CAP, WB_REQ, FILL_REQ, FILL_WAIT, FILL_WR, FIN.
REQ-006 IDLE: miss_req with victim_dirty=1 -> WB_RD; victim_dirty=0 -> FILL_REQ.
REQ-007 WB_RD: ram_ren_all=1 for exactly one cycle, ram_radr_all=victim_adr[DWIDTH+1:4]; -> WB_CAP.
REQ-008 WB_CAP: capture ram_rdata_all into 128-bit line buffer; -> WB_REQ.
REQ-009 WB_REQ: mem_req=1, mem_we=1, mem_adr=victim_adr, mem_wdata=buffer, all stable until mem_ack; cycle with mem_ack -> FILL_REQ.
REQ-010 FILL_REQ: mem_req=1, mem_we=0, mem_adr=miss_adr, stable until mem_ack; cycle with mem_ack -> FILL_WAIT.
REQ-011 FILL_WAIT: on mem_rvalid capture mem_rdata into buffer; -> FILL_WR. mem_rvalid in same cycle as mem_ack (FILL_REQ) SHALL be captured and skip FILL_WAIT.
REQ-012 FILL_WR: ram_wen_all=1 one cycle, ram_wadr_all=miss_adr[DWIDTH+1:4], ram_wdata_all=buffer; -> FIN.
REQ-013 FIN: dc_stall_fin=1, tag_upd=1 one cycle; -> IDLE.
REQ-014 busy SHALL be 1 in every state but IDLE, combinational from state.
REQ-015 mem_req SHALL deassert the cycle after mem_ack; mem_ack while mem_req=0 SHALL be ignored; mem_rvalid outside FILL_WAIT/FILL_REQ SHALL be ignored.
REQ-016 ram_ren_all and ram_wen_all SHALL never assert in the same cycle.
REQ-017 Minimum latency miss_req to dc_stall_fin: clean = 4 cycles given mem_ack and mem_rvalid in first FILL_REQ cycle; dirty = +3 with immediate mem_ack.
REQ-018 Address bits above DWIDTH+1 SHALL reach mem_adr only; RAM index truncation is not an error.
REQ-019 No timeout: controller SHALL wait indefinitely for mem_ack/mem_rvalid.

Reset
REQ-020 rst_n=0 at clk edge SHALL force IDLE, all outputs 0, buffer and captured addresses 0, from any state including mid-transaction with mem_req high.
REQ-021 After reset release, first miss_req SHALL be accepted the first cycle rst_n=1.

Verification
REQ-022 Clean miss, miss_adr=0x0000123, immediate ack/rvalid with mem_rdata=0xA5...A5 -> one mem_req we=0 adr 0x0000123, ram_wen_all index 0x123 data A5..A5, dc_stall_fin 4 cycles after miss_req.
REQ-023 Dirty miss, victim_adr=0x0000456, ram_rdata_all=0x1111...1111 -> ram_ren_all index 0x456, then mem_req we=1 adr 0x0000456 wdata 1111..1111, then fill read, then one dc_stall_fin.
REQ-024 mem_ack delayed 5 cycles in WB_REQ -> mem_req, mem_we, mem_adr, mem_wdata unchanged all 5 cycles; no RAM access meanwhile.
REQ-025 miss_req pulses while busy -> ignored; exactly one fill and one dc_stall_fin.
REQ-026 rst_n=0 in FILL_WAIT -> next cycle busy=0, mem_req=0, no ram_wen_all; later mem_rvalid ignored.
REQ-027 miss_adr=0xFFFFFFF, DWIDTH=14 -> mem_adr 0xFFFFFFF, ram_wadr_all 0xFFF.

Source files
------------

// File: rtl/dc_line_ctrl_if.sv
// External memory port of the data-cache line controller.
// One request channel (req/we/adr/wdata with ack) and one fill-return
// channel (rvalid/rdata). The controller is the master.
interface dc_line_ctrl_if;
  logic         mem_req;
  logic         mem_we;
  logic [27:0]  mem_adr;
  logic [127:0] mem_wdata;
  logic         mem_ack;
  logic         mem_rvalid;
  logic [127:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_adr, mem_wdata,
    input  mem_ack, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_adr, mem_wdata,
    output mem_ack, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/dc_line_ctrl.sv
// Data-cache line miss controller.
// On a miss it optionally writes the dirty victim line back to memory
// (read it from the data RAM, send it out), then reads the missing line
// from memory, writes it into the data RAM and pulses dc_stall_fin/tag_upd.
// One miss at a time; requests arriving while busy are dropped.
module dc_line_ctrl #(
  parameter int DWIDTH = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miss_req,
  input  logic [27:0]       miss_adr,
  input  logic              victim_dirty,
  input  logic [27:0]       victim_adr,
  output logic [DWIDTH-3:0] ram_radr_all,
  output logic              ram_ren_all,
  input  logic [127:0]      ram_rdata_all,
  output logic [DWIDTH-3:0] ram_wadr_all,
  output logic [127:0]      ram_wdata_all,
  output logic              ram_wen_all,
  dc_line_ctrl_if.master    mem,
  output logic              busy,
  output logic              dc_stall_fin,
  output logic              tag_upd
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB_RD,
    S_WB_CAP,
    S_WB_REQ,
    S_FILL_REQ,
    S_FILL_WAIT,
    S_FILL_WR,
    S_FIN
  } state_e;

  state_e             state_q;
  logic [27:0]        miss_adr_q;
  logic [27:0]        victim_adr_q;
  logic               victim_dirty_q;
  logic [127:0]       line_buf_q;

  logic               ram_ren_q;
  logic [DWIDTH-3:0]  ram_radr_q;
  logic               ram_wen_q;
  logic [DWIDTH-3:0]  ram_wadr_q;
  logic               mem_req_q;
  logic               mem_we_q;
  logic [27:0]        mem_adr_q;
  logic               fin_q;

  // Line-address bits [DWIDTH+1:4] form the RAM index; the rest only go to memory.
  function automatic logic [DWIDTH-3:0] line_index(input logic [27:0] adr);
    return adr[DWIDTH-3:0];
  endfunction

  // Main FSM: state, captured miss context, line buffer and registered outputs.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of the others; blocking here would create ordering races.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the line buffer is a plain 128-bit register, not a memory array,
      // so it is reset like everything else and never leaks stale data.
      state_q        <= S_IDLE;
      miss_adr_q     <= '0;
      victim_adr_q   <= '0;
      victim_dirty_q <= 1'b0;
      line_buf_q     <= '0;
      ram_ren_q      <= 1'b0;
      ram_radr_q     <= '0;
      ram_wen_q      <= 1'b0;
      ram_wadr_q     <= '0;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_adr_q      <= '0;
      fin_q          <= 1'b0;
    end else begin
      // Single-cycle strobes default low; states below raise them for one cycle.
      ram_ren_q <= 1'b0;
      ram_wen_q <= 1'b0;
      fin_q     <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          if (miss_req) begin
            miss_adr_q     <= miss_adr;
            victim_adr_q   <= victim_adr;
            victim_dirty_q <= victim_dirty;
            if (victim_dirty) begin
              state_q    <= S_WB_RD;
              ram_ren_q  <= 1'b1;
              ram_radr_q <= line_index(victim_adr);
            end else begin
              state_q   <= S_FILL_REQ;
              mem_req_q <= 1'b1;
              mem_we_q  <= 1'b0;
              mem_adr_q <= miss_adr;
            end
          end
        end

        // RAM read issued this cycle; data arrives next cycle.
        S_WB_RD: state_q <= S_WB_CAP;

        S_WB_CAP: begin
          line_buf_q <= ram_rdata_all;
          state_q    <= S_WB_REQ;
          mem_req_q  <= 1'b1;
          mem_we_q   <= victim_dirty_q;
          mem_adr_q  <= victim_adr_q;
        end

        // Writeback request held until accepted, then the fill read follows at once.
        S_WB_REQ: begin
          if (mem.mem_ack) begin
            state_q   <= S_FILL_REQ;
            mem_req_q <= 1'b1;
            mem_we_q  <= 1'b0;
            mem_adr_q <= miss_adr_q;
          end
        end

        // Fill data coming back in the ack cycle is taken immediately.
        S_FILL_REQ: begin
          if (mem.mem_ack) begin
            mem_req_q <= 1'b0;
            if (mem.mem_rvalid) begin
              line_buf_q <= mem.mem_rdata;
              state_q    <= S_FILL_WR;
              ram_wen_q  <= 1'b1;
              ram_wadr_q <= line_index(miss_adr_q);
            end else begin
              state_q <= S_FILL_WAIT;
            end
          end
        end

        S_FILL_WAIT: begin
          if (mem.mem_rvalid) begin
            line_buf_q <= mem.mem_rdata;
            state_q    <= S_FILL_WR;
            ram_wen_q  <= 1'b1;
            ram_wadr_q <= line_index(miss_adr_q);
          end
        end

        S_FILL_WR: begin
          state_q <= S_FIN;
          fin_q   <= 1'b1;
        end

        S_FIN: state_q <= S_IDLE;

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ram_ren_all   = ram_ren_q;
  assign ram_radr_all  = ram_radr_q;
  assign ram_wen_all   = ram_wen_q;
  assign ram_wadr_all  = ram_wadr_q;
  assign ram_wdata_all = line_buf_q;

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_adr   = mem_adr_q;
  assign mem.mem_wdata = line_buf_q;

  assign busy          = (state_q != S_IDLE);
  assign dc_stall_fin  = fin_q;
  assign tag_upd       = fin_q;

endmodule

// File: tb/tb_dc_line_ctrl.sv
// Self-checking bench for dc_line_ctrl: a scoreboard of expected RAM reads,
// memory requests, RAM writes and finish pulses, filled when a miss is issued
// and drained by a negedge monitor / memory responder.
module tb_dc_line_ctrl;

  localparam int DW = 14;
  localparam int IW = DW - 2;

  typedef enum int {EV_RD, EV_MEM_WB, EV_MEM_FILL, EV_WR, EV_FIN} ev_kind_e;
  typedef struct {
    ev_kind_e     kind;
    logic [27:0]  adr;
    logic [127:0] data;
    int           lat;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          miss_req = 1'b0;
  logic [27:0]   miss_adr = '0;
  logic          victim_dirty = 1'b0;
  logic [27:0]   victim_adr = '0;
  logic [IW-1:0] ram_radr_all;
  logic          ram_ren_all;
  logic [127:0]  ram_rdata_all = '0;
  logic [IW-1:0] ram_wadr_all;
  logic [127:0]  ram_wdata_all;
  logic          ram_wen_all;
  logic          busy;
  logic          dc_stall_fin;
  logic          tag_upd;

  dc_line_ctrl_if mem_if ();

  dc_line_ctrl #(.DWIDTH(DW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .miss_req      (miss_req),
    .miss_adr      (miss_adr),
    .victim_dirty  (victim_dirty),
    .victim_adr    (victim_adr),
    .ram_radr_all  (ram_radr_all),
    .ram_ren_all   (ram_ren_all),
    .ram_rdata_all (ram_rdata_all),
    .ram_wadr_all  (ram_wadr_all),
    .ram_wdata_all (ram_wdata_all),
    .ram_wen_all   (ram_wen_all),
    .mem           (mem_if.master),
    .busy          (busy),
    .dc_stall_fin  (dc_stall_fin),
    .tag_upd       (tag_upd)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t0      = 0;

  ev_t exp_q[$];

  // Memory responder knobs.
  int           ack_dly   = 0;
  int           rv_dly    = 0;
  logic [127:0] fill_data = '0;
  bit           stray     = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Pop the next expected event and confirm it is of the observed kind.
  task automatic pop_ev(input ev_kind_e kind, output ev_t e, output bit ok);
    ok = 1'b0;
    e  = '{kind: EV_RD, adr: '0, data: '0, lat: 0};
    if (exp_q.size() == 0) begin
      check($sformatf("unexpected_ev%0d", int'(kind)), 1, 0);
    end else begin
      e = exp_q.pop_front();
      check("ev_kind", int'(kind), int'(e.kind));
      ok = (e.kind == kind);
    end
  endtask

  // Monitor plus memory model, all sampled on the falling edge.
  initial begin
    int           req_cnt;
    int           rv_left;
    bit           fill_pending;
    logic         snap_we;
    logic [27:0]  snap_adr;
    logic [127:0] snap_wdata;
    ev_t          e;
    bit           ok;
    req_cnt      = 0;
    rv_left      = 0;
    fill_pending = 1'b0;
    mem_if.mem_ack    = 1'b0;
    mem_if.mem_rvalid = 1'b0;
    mem_if.mem_rdata  = '0;
    forever begin
      @(negedge clk);
      mem_if.mem_ack    = 1'b0;
      mem_if.mem_rvalid = 1'b0;

      if (ram_ren_all === 1'b1 && ram_wen_all === 1'b1)
        check("ren_wen_overlap", 1, 0);
      if (dc_stall_fin === 1'b1 || tag_upd === 1'b1)
        check("tag_upd_vs_fin", tag_upd, dc_stall_fin);

      if (ram_ren_all === 1'b1) begin
        pop_ev(EV_RD, e, ok);
        if (ok) check("ram_radr", ram_radr_all, e.adr[IW-1:0]);
      end
      if (ram_wen_all === 1'b1) begin
        pop_ev(EV_WR, e, ok);
        if (ok) begin
          check("ram_wadr", ram_wadr_all, e.adr[IW-1:0]);
          check("ram_wdata", ram_wdata_all, e.data);
        end
      end
      if (dc_stall_fin === 1'b1) begin
        pop_ev(EV_FIN, e, ok);
        if (ok && e.lat != 0) check("fin_latency", cyc - t0 + 1, e.lat);
      end

      if (mem_if.mem_req === 1'b1) begin
        check("no_ram_during_req", ram_ren_all | ram_wen_all, 0);
        if (req_cnt == 0) begin
          snap_we    = mem_if.mem_we;
          snap_adr   = mem_if.mem_adr;
          snap_wdata = mem_if.mem_wdata;
        end else begin
          check("req_we_stable", mem_if.mem_we, snap_we);
          check("req_adr_stable", mem_if.mem_adr, snap_adr);
          if (snap_we) check("req_wdata_stable", mem_if.mem_wdata, snap_wdata);
        end
        if (req_cnt >= ack_dly) begin
          mem_if.mem_ack = 1'b1;
          req_cnt = 0;
          if (mem_if.mem_we === 1'b1) begin
            pop_ev(EV_MEM_WB, e, ok);
            if (ok) begin
              check("wb_adr", mem_if.mem_adr, e.adr);
              check("wb_wdata", mem_if.mem_wdata, e.data);
            end
          end else begin
            pop_ev(EV_MEM_FILL, e, ok);
            if (ok) check("fill_adr", mem_if.mem_adr, e.adr);
            if (rv_dly == 0) begin
              mem_if.mem_rvalid = 1'b1;
              mem_if.mem_rdata  = fill_data;
            end else begin
              fill_pending = 1'b1;
              rv_left      = rv_dly;
            end
          end
        end else begin
          req_cnt++;
        end
      end else begin
        req_cnt = 0;
        if (stray) begin
          mem_if.mem_ack    = 1'b1;
          mem_if.mem_rvalid = 1'b1;
          mem_if.mem_rdata  = ~fill_data;
          stray = 1'b0;
        end else if (fill_pending) begin
          rv_left--;
          if (rv_left == 0) begin
            mem_if.mem_rvalid = 1'b1;
            mem_if.mem_rdata  = fill_data;
            fill_pending      = 1'b0;
          end
        end
      end
    end
  end

  // Wait (bounded) for the controller to go idle with all events consumed.
  task automatic wait_done(input bit spam);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (busy === 1'b0 && exp_q.size() == 0) done = 1'b1;
      miss_req = spam && (busy === 1'b1) && (i % 2 == 0);
      if (spam) begin
        miss_adr     = 28'h0BAD000 + 28'(i);
        victim_dirty = 1'b1;
        victim_adr   = 28'h0DEAD00 + 28'(i);
      end
    end
    miss_req = 1'b0;
    check("done_in_time", done, 1);
    check("sb_empty", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Issue one miss from a falling edge and queue the whole expected sequence.
  task automatic issue_miss(input logic [27:0] adr, input bit dirty, input logic [27:0] vadr,
                            input logic [127:0] ramdata, input logic [127:0] fdata,
                            input int a_dly, input int r_dly, input int lat);
    ack_dly       = a_dly;
    rv_dly        = r_dly;
    fill_data     = fdata;
    ram_rdata_all = ramdata;
    if (dirty) begin
      exp_q.push_back('{kind: EV_RD, adr: vadr, data: '0, lat: 0});
      exp_q.push_back('{kind: EV_MEM_WB, adr: vadr, data: ramdata, lat: 0});
    end
    exp_q.push_back('{kind: EV_MEM_FILL, adr: adr, data: '0, lat: 0});
    exp_q.push_back('{kind: EV_WR, adr: adr, data: fdata, lat: 0});
    exp_q.push_back('{kind: EV_FIN, adr: adr, data: '0, lat: lat});
    miss_adr     = adr;
    victim_dirty = dirty;
    victim_adr   = vadr;
    miss_req     = 1'b1;
    t0           = cyc;
  endtask

  task automatic run_miss(input logic [27:0] adr, input bit dirty, input logic [27:0] vadr,
                          input logic [127:0] ramdata, input logic [127:0] fdata,
                          input int a_dly, input int r_dly, input int lat, input bit spam);
    issue_miss(adr, dirty, vadr, ramdata, fdata, a_dly, r_dly, lat);
    wait_done(spam);
  endtask

  initial begin
    bit seen;
    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_mem_req", mem_if.mem_req, 0);
    check("rst_ram_ren", ram_ren_all, 0);
    check("rst_ram_wen", ram_wen_all, 0);
    check("rst_fin", dc_stall_fin, 0);
    check("rst_mem_adr", mem_if.mem_adr, 0);
    check("rst_wdata", ram_wdata_all, 0);

    // Clean miss accepted in the first cycle out of reset, minimum latency.
    rst_n = 1'b1;
    run_miss(28'h0000123, 1'b0, 28'h0000999, '0, {16{8'hA5}}, 0, 0, 4, 1'b0);

    // Dirty miss, immediate ack and data: writeback then fill.
    run_miss(28'h0000789, 1'b1, 28'h0000456, {32{4'h1}}, {32{4'h2}}, 0, 0, 7, 1'b0);

    // Slow memory: 5-cycle acks, data 3 cycles after fill ack.
    run_miss(28'h1234ABC, 1'b1, 28'h7654321, {4{32'hCAFEF00D}}, {4{32'h0BADBEEF}}, 5, 3, 0, 1'b0);

    // Delayed ack with data in the ack cycle.
    run_miss(28'h0000ACE, 1'b0, 28'h0, '0, {8{16'h5A3C}}, 2, 0, 0, 1'b0);

    // miss_req pulses while busy are dropped.
    run_miss(28'h0000321, 1'b0, 28'h0, '0, {4{32'h13579BDF}}, 4, 2, 0, 1'b1);

    // Wide address: upper bits reach memory only.
    run_miss(28'hFFFFFFF, 1'b0, 28'h0, '0, {4{32'h89ABCDEF}}, 0, 0, 4, 1'b0);
    run_miss(28'h0000001, 1'b1, 28'hABCDEF1, {4{32'h600DF00D}}, {4{32'h0000FFFF}}, 0, 1, 0, 1'b0);

    // Reset while waiting for fill data; the late rvalid must be ignored.
    issue_miss(28'h0000654, 1'b0, 28'h0, '0, {4{32'h77777777}}, 0, 10, 0);
    @(negedge clk);
    miss_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("fw_rst_busy", busy, 0);
    check("fw_rst_mem_req", mem_if.mem_req, 0);
    check("fw_rst_ram_wen", ram_wen_all, 0);
    check("fw_rst_wdata", ram_wdata_all, 0);
    exp_q.delete();
    repeat (14) @(negedge clk);
    check("fw_after_busy", busy, 0);

    // Reset with mem_req held high in the writeback request.
    issue_miss(28'h0000111, 1'b1, 28'h0000222, {4{32'h44444444}}, '0, 50, 0, 0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      miss_req = 1'b0;
      if (mem_if.mem_req === 1'b1) seen = 1'b1;
    end
    check("wb_req_seen", seen, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("wb_rst_mem_req", mem_if.mem_req, 0);
    check("wb_rst_busy", busy, 0);
    check("wb_rst_mem_adr", mem_if.mem_adr, 0);
    check("wb_rst_mem_wdata", mem_if.mem_wdata, 0);
    exp_q.delete();

    // Stray ack/rvalid while idle do nothing.
    stray = 1'b1;
    repeat (4) @(negedge clk);
    check("stray_busy", busy, 0);
    check("stray_mem_req", mem_if.mem_req, 0);
    check("stray_ram_wen", ram_wen_all, 0);

    // Recovery after the mid-transaction resets.
    run_miss(28'h0000ABC, 1'b0, 28'h0, '0, {4{32'h31415926}}, 0, 0, 4, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
